// File: rtl/mips_pkg.sv
// Shared opcodes, funct codes, field slices and control bundle for mips_cpu.
// Optional jal/jr support is enabled by defining CPU_JAL_EN.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    WR_RD,
    WR_RT,
    WR_RA
  } wr_sel_t;

  typedef struct packed {
    logic    reg_we;
    wr_sel_t wr_sel;
    logic    imm_src;
    logic    imm_zext;
    logic    mem_we;
    logic    mem_rd;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    link;
    logic    jr;
    alu_op_t alu_op;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for mips_cpu: arithmetic, logic, compares, shifts, lui.
// Shifts operate on b by shamt; lui places b[15:0] in the upper half.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_LUI:  result = {b[15:0], 16'b0};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset core with internal register file and memories.
// Define CPU_JAL_EN to enable jal/jr; otherwise both decode as NOP.
module mips_cpu
  import mips_pkg::*;
(
  input logic clk,
  input logic rst_n
);

  reg [31:0] RegisterFile [0:31];
  reg [31:0] IMemory      [0:1023];
  reg [31:0] DMemory      [0:1023];

  // initialiser gives PC=0 even when reset is never pulsed
  logic [31:0] pc = '0;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;

  ctrl_t       c;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic [31:0] dmem_rdata;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign instr  = IMemory[pc[11:2]];
  assign opcode = instr[OP_HI:OP_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign shamt  = instr[SH_HI:SH_LO];
  assign funct  = instr[FN_HI:FN_LO];
  assign imm    = instr[IMM_HI:IMM_LO];
  assign target = instr[TGT_HI:TGT_LO];

  always_comb begin
    c        = '0;
    c.alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        c.wr_sel = WR_RD;
        case (funct)
          FN_ADD, FN_ADDU: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_ADD;
          end
          FN_SUB, FN_SUBU: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_SUB;
          end
          FN_AND: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_AND;
          end
          FN_OR: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_OR;
          end
          FN_XOR: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_XOR;
          end
          FN_NOR: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_NOR;
          end
          FN_SLT: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_SLT;
          end
          FN_SLTU: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_SLTU;
          end
          FN_SLL: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_SLL;
          end
          FN_SRL: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_SRL;
          end
          FN_SRA: begin
            c.reg_we = 1'b1;
            c.alu_op = ALU_SRA;
          end
`ifdef CPU_JAL_EN
          FN_JR: c.jr = 1'b1;
`endif
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        c.reg_we  = 1'b1;
        c.wr_sel  = WR_RT;
        c.imm_src = 1'b1;
        c.alu_op  = ALU_ADD;
      end
      OP_SLTI: begin
        c.reg_we  = 1'b1;
        c.wr_sel  = WR_RT;
        c.imm_src = 1'b1;
        c.alu_op  = ALU_SLT;
      end
      OP_ANDI: begin
        c.reg_we   = 1'b1;
        c.wr_sel   = WR_RT;
        c.imm_src  = 1'b1;
        c.imm_zext = 1'b1;
        c.alu_op   = ALU_AND;
      end
      OP_ORI: begin
        c.reg_we   = 1'b1;
        c.wr_sel   = WR_RT;
        c.imm_src  = 1'b1;
        c.imm_zext = 1'b1;
        c.alu_op   = ALU_OR;
      end
      OP_XORI: begin
        c.reg_we   = 1'b1;
        c.wr_sel   = WR_RT;
        c.imm_src  = 1'b1;
        c.imm_zext = 1'b1;
        c.alu_op   = ALU_XOR;
      end
      OP_LUI: begin
        c.reg_we   = 1'b1;
        c.wr_sel   = WR_RT;
        c.imm_src  = 1'b1;
        c.imm_zext = 1'b1;
        c.alu_op   = ALU_LUI;
      end
      OP_LW: begin
        c.reg_we  = 1'b1;
        c.wr_sel  = WR_RT;
        c.imm_src = 1'b1;
        c.mem_rd  = 1'b1;
      end
      OP_SW: begin
        c.imm_src = 1'b1;
        c.mem_we  = 1'b1;
      end
      OP_BEQ: begin
        c.beq    = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        c.bne    = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_J: c.jump = 1'b1;
`ifdef CPU_JAL_EN
      OP_JAL: begin
        c.jump   = 1'b1;
        c.link   = 1'b1;
        c.reg_we = 1'b1;
        c.wr_sel = WR_RA;
      end
`endif
      default: ;
    endcase
  end

  assign rs_val = (rs == 5'd0) ? '0 : RegisterFile[rs];
  assign rt_val = (rt == 5'd0) ? '0 : RegisterFile[rt];

  assign imm_ext = c.imm_zext ? {16'b0, imm} : sext16(imm);
  assign alu_b   = c.imm_src ? imm_ext : rt_val;

  mips_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .shamt  (shamt),
    .op     (c.alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign dmem_rdata = DMemory[alu_res[11:2]];

  always_comb begin
    wr_addr = rd;
    unique case (c.wr_sel)
      WR_RD:   wr_addr = rd;
      WR_RT:   wr_addr = rt;
      WR_RA:   wr_addr = 5'd31;
      default: wr_addr = rd;
    endcase
  end

  assign wr_data = c.link   ? pc_plus4   :
                   c.mem_rd ? dmem_rdata : alu_res;

  assign pc_plus4   = pc + 32'd4;
  assign br_target  = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], target, 2'b00};
  assign br_taken   = (c.beq & alu_zero) | (c.bne & ~alu_zero);

  always_comb begin
    pc_next = pc_plus4;
    unique case (1'b1)
      br_taken: pc_next = br_target;
      c.jump:   pc_next = jmp_target;
      c.jr:     pc_next = rs_val;
      default:  pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= pc_next;
  end

  // arrays are never reset; writes simply hold off while reset is low
  always_ff @(posedge clk) begin
    if (rst_n && c.reg_we && wr_addr != 5'd0)
      RegisterFile[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && c.mem_we)
      DMemory[alu_res[11:2]] <= rt_val;
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: single-instruction vector table plus
// multi-instruction programs checked through a scoreboard queue.
module tb_mips_cpu;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mips_cpu dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } sb_t;

  localparam int K_REG = 0;
  localparam int K_MEM = 1;
  localparam int K_PC  = 2;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] SELF_LOOP = {OP_BEQ, 5'd0, 5'd0, 16'hFFFF};

  function automatic logic [31:0] enc_r(input logic [5:0] fn,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op,
    input logic [25:0] t);
    return {op, t};
  endfunction

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_REG:   return dut.RegisterFile[idx];
      K_MEM:   return dut.DMemory[idx];
      default: return dut.pc;
    endcase
  endfunction

  task automatic expect_val(input string name, input int kind,
    input int idx, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = actual(e.kind, e.idx);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic load_begin();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.IMemory[i] = 32'h0;
    for (int i = 0; i < 32; i++) dut.RegisterFile[i] = 32'h0;
  endtask

  task automatic load_end();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs.push_back('{"add", enc_r(FN_ADD, 1, 2, 3, 0), 5, 7, 12});
    vecs.push_back('{"sub", enc_r(FN_SUB, 1, 2, 3, 0), 5, 7, 32'hFFFFFFFE});
    vecs.push_back('{"add_ovf", enc_r(FN_ADD, 1, 2, 3, 0),
                     32'h7FFFFFFF, 1, 32'h80000000});
    vecs.push_back('{"addu", enc_r(FN_ADDU, 1, 2, 3, 0),
                     32'hFFFFFFFF, 2, 1});
    vecs.push_back('{"subu", enc_r(FN_SUBU, 1, 2, 3, 0), 0, 1, 32'hFFFFFFFF});
    vecs.push_back('{"and", enc_r(FN_AND, 1, 2, 3, 0),
                     32'hF0F0, 32'hFF00, 32'hF000});
    vecs.push_back('{"or", enc_r(FN_OR, 1, 2, 3, 0),
                     32'hF0F0, 32'hFF00, 32'hFFF0});
    vecs.push_back('{"xor", enc_r(FN_XOR, 1, 2, 3, 0),
                     32'hF0F0, 32'hFF00, 32'h0FF0});
    vecs.push_back('{"nor", enc_r(FN_NOR, 1, 2, 3, 0),
                     32'hF0F0, 32'hFF00, 32'hFFFF000F});
    vecs.push_back('{"slt", enc_r(FN_SLT, 1, 2, 3, 0), 32'hFFFFFFFE, 5, 1});
    vecs.push_back('{"sltu", enc_r(FN_SLTU, 1, 2, 3, 0), 32'hFFFFFFFE, 5, 0});
    vecs.push_back('{"sra", enc_r(FN_SRA, 0, 2, 3, 4),
                     0, 32'h80000000, 32'hF8000000});
    vecs.push_back('{"srl", enc_r(FN_SRL, 0, 2, 3, 4),
                     0, 32'h80000000, 32'h08000000});
    vecs.push_back('{"sll", enc_r(FN_SLL, 0, 2, 3, 1), 0, 32'h80000000, 0});
    vecs.push_back('{"addi", enc_i(OP_ADDI, 1, 3, 16'hFFFF), 5, 0, 4});
    vecs.push_back('{"addiu", enc_i(OP_ADDIU, 1, 3, 16'h8000),
                     0, 0, 32'hFFFF8000});
    vecs.push_back('{"slti0", enc_i(OP_SLTI, 1, 3, 16'hFFFF), 5, 0, 0});
    vecs.push_back('{"slti1", enc_i(OP_SLTI, 1, 3, 16'hFFFF),
                     32'hFFFFFFFE, 0, 1});
    vecs.push_back('{"andi", enc_i(OP_ANDI, 1, 3, 16'hFFFF),
                     32'h12345678, 0, 32'h5678});
    vecs.push_back('{"ori", enc_i(OP_ORI, 1, 3, 16'h8000),
                     32'hFFFF0000, 0, 32'hFFFF8000});
    vecs.push_back('{"xori", enc_i(OP_XORI, 1, 3, 16'h00FF),
                     32'hFFFFFFFF, 0, 32'hFFFFFF00});
    vecs.push_back('{"lui", enc_i(OP_LUI, 0, 3, 16'h1234),
                     0, 0, 32'h12340000});
    vecs.push_back('{"bad_funct", enc_r(6'h3F, 1, 2, 3, 0),
                     5, 7, 32'hA5A5A5A5});
    vecs.push_back('{"bad_op", enc_i(6'h3F, 1, 3, 16'h0001),
                     5, 7, 32'hA5A5A5A5});

    // reset state before any clock edge
    #1;
    expect_val("pc_reset", K_PC, 0, 32'h0);
    drain();

    foreach (vecs[k]) begin
      load_begin();
      dut.RegisterFile[1] = vecs[k].a;
      dut.RegisterFile[2] = vecs[k].b;
      dut.RegisterFile[3] = 32'hA5A5A5A5;
      dut.IMemory[0] = vecs[k].instr;
      dut.IMemory[1] = SELF_LOOP;
      expect_val(vecs[k].name, K_REG, 3, vecs[k].exp);
      load_end();
      run(3);
      drain();
    end

    // lui/ori/sw/lw round trip
    load_begin();
    dut.DMemory[2] = 32'h0;
    dut.IMemory[0] = enc_i(OP_LUI, 0, 1, 16'h1234);
    dut.IMemory[1] = enc_i(OP_ORI, 1, 1, 16'h5678);
    dut.IMemory[2] = enc_i(OP_SW, 0, 1, 16'd8);
    dut.IMemory[3] = enc_i(OP_LW, 0, 2, 16'd8);
    dut.IMemory[4] = SELF_LOOP;
    expect_val("sw_mem", K_MEM, 2, 32'h12345678);
    expect_val("lw_reg", K_REG, 2, 32'h12345678);
    expect_val("mem_pc", K_PC, 0, 32'h10);
    load_end();
    run(8);
    drain();

    // branches, register 0, branch-to-self
    load_begin();
    dut.RegisterFile[5] = 32'h55;
    dut.IMemory[0] = enc_i(OP_BEQ, 0, 0, 16'd1);
    dut.IMemory[1] = enc_i(OP_ADDI, 0, 5, 16'd1);
    dut.IMemory[2] = enc_i(OP_ADDI, 0, 6, 16'd2);
    dut.IMemory[3] = enc_i(OP_BNE, 0, 0, 16'd1);
    dut.IMemory[4] = enc_i(OP_ADDI, 0, 7, 16'd3);
    dut.IMemory[5] = enc_i(OP_ADDI, 0, 0, 16'd9);
    dut.IMemory[6] = SELF_LOOP;
    expect_val("beq_skip", K_REG, 5, 32'h55);
    expect_val("after_beq", K_REG, 6, 32'd2);
    expect_val("bne_fall", K_REG, 7, 32'd3);
    expect_val("reg0", K_REG, 0, 32'd0);
    expect_val("self_pc", K_PC, 0, 32'h18);
    load_end();
    run(10);
    drain();
    run(1000);
    expect_val("self_pc_1000", K_PC, 0, 32'h18);
    drain();

    // jal / jr
    load_begin();
    dut.RegisterFile[31] = 32'hBEEF;
    dut.IMemory[4] = enc_j(OP_JAL, 26'd8);
    dut.IMemory[5] = SELF_LOOP;
    dut.IMemory[8] = enc_i(OP_ADDI, 0, 8, 16'd7);
    dut.IMemory[9] = enc_r(FN_JR, 31, 0, 0, 0);
`ifdef CPU_JAL_EN
    expect_val("jal_ra", K_REG, 31, 32'h14);
    expect_val("jal_body", K_REG, 8, 32'd7);
`else
    expect_val("jal_nop_ra", K_REG, 31, 32'hBEEF);
    expect_val("jal_nop_body", K_REG, 8, 32'd0);
`endif
    expect_val("jal_pc", K_PC, 0, 32'h14);
    load_end();
    run(14);
    drain();

    // j loop with mid-run reset
    load_begin();
    dut.DMemory[0] = 32'h0;
    dut.DMemory[5] = 32'hCAFE;
    dut.IMemory[0] = enc_i(OP_ADDI, 1, 1, 16'd1);
    dut.IMemory[1] = enc_i(OP_SW, 0, 1, 16'd0);
    dut.IMemory[2] = enc_j(OP_J, 26'd0);
    load_end();
    run(10);
    #1 rst_n = 1'b0;
    #1;
    expect_val("async_rst_pc", K_PC, 0, 32'h0);
    drain();
    run(3);
    expect_val("rst_reg_hold", K_REG, 1, 32'd4);
    expect_val("rst_mem_hold", K_MEM, 0, 32'd3);
    expect_val("rst_mem_other", K_MEM, 5, 32'hCAFE);
    expect_val("rst_pc_held", K_PC, 0, 32'h0);
    drain();
    rst_n = 1'b1;
    run(3);
    expect_val("resume_reg", K_REG, 1, 32'd5);
    expect_val("resume_mem", K_MEM, 0, 32'd5);
    expect_val("resume_pc", K_PC, 0, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
